// File: rtl/row_buff_pingpong.sv
// rtl/row_buff_pingpong.sv - two-bank ping-pong row collector presenting whole matrices
module row_buff_pingpong #(
  parameter int DATA_SIZE   = 16,
  parameter int ROW_SIZE    = 16,
  parameter int COLUMN_SIZE = 16
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic                                       din_valid,
  output logic                                       din_ready,
  input  logic [DATA_SIZE*ROW_SIZE-1:0]              dats,
  input  logic                                       dendFlag,
  input  logic                                       transpose,
  output logic                                       dsetFlag,
  input  logic                                       dout_ready,
  output logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0]  datsOut,
  output logic [$clog2(COLUMN_SIZE+1)-1:0]           rowCount
);

  localparam int RW = DATA_SIZE * ROW_SIZE;
  localparam int CW = $clog2(COLUMN_SIZE + 1);
  localparam int AW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t     bank_state     [2];
  logic [CW-1:0]   bank_rows      [2];
  logic            bank_transpose [2];
  logic [RW-1:0]   bank_mem       [2][COLUMN_SIZE];

  logic [CW-1:0]   wr_cnt;
  logic            fill_ptr;
  logic            rd_ptr;

  logic [CW-1:0]   wr_cnt_next;
  logic            accept;
  logic            close_on_beat;
  logic            close_idle;
  logic            close_bank;
  logic            out_fire;

  // The fill bank accepts rows until it is closed; a full fill bank stalls the producer.
  assign din_ready     = enable && reset && (bank_state[fill_ptr] != BANK_FULL);
  assign accept        = din_valid && din_ready;
  assign wr_cnt_next   = wr_cnt + CW'(1);
  assign close_on_beat = accept && (dendFlag || (wr_cnt_next == CW'(COLUMN_SIZE)));
  // A bare end flag only closes a bank that already holds rows; empty matrices never appear.
  assign close_idle    = enable && !accept && dendFlag && (wr_cnt != '0);
  assign close_bank    = close_on_beat || close_idle;

  assign dsetFlag = (bank_state[rd_ptr] == BANK_FULL);
  assign out_fire = dsetFlag && dout_ready && enable;
  assign rowCount = dsetFlag ? bank_rows[rd_ptr] : '0;

  // Bank lifecycle, row counter and the two ring pointers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b]     <= BANK_EMPTY;
        bank_rows[b]      <= '0;
        bank_transpose[b] <= 1'b0;
      end
      wr_cnt   <= '0;
      fill_ptr <= 1'b0;
      rd_ptr   <= 1'b0;
    end else if (enable) begin
      // The read bank is FULL and the fill bank is not, so these never target the same bank.
      if (out_fire) begin
        bank_state[rd_ptr] <= BANK_EMPTY;
        rd_ptr             <= ~rd_ptr;
      end
      if (accept) begin
        bank_state[fill_ptr] <= BANK_FILLING;
        if (wr_cnt == '0) begin
          bank_transpose[fill_ptr] <= transpose;
        end
      end
      if (close_bank) begin
        bank_state[fill_ptr] <= BANK_FULL;
        bank_rows[fill_ptr]  <= accept ? wr_cnt_next : wr_cnt;
        wr_cnt               <= '0;
        fill_ptr             <= ~fill_ptr;
      end else if (accept) begin
        wr_cnt <= wr_cnt_next;
      end
    end
  end

  // Row storage; stale rows are never visible because reads are masked by the row count.
  always_ff @(posedge clock) begin
    if (accept) begin
      bank_mem[fill_ptr][AW'(wr_cnt)] <= dats;
    end
  end

  // Present the read bank in the layout latched with its first row, zero beyond rowCount.
  always_comb begin
    datsOut = '0;
    if (dsetFlag) begin
      for (int r = 0; r < COLUMN_SIZE; r++) begin
        if (CW'(r) < bank_rows[rd_ptr]) begin
          for (int c = 0; c < ROW_SIZE; c++) begin
            if (bank_transpose[rd_ptr]) begin
              datsOut[(c*COLUMN_SIZE + r)*DATA_SIZE +: DATA_SIZE] =
                bank_mem[rd_ptr][AW'(r)][c*DATA_SIZE +: DATA_SIZE];
            end else begin
              datsOut[(r*ROW_SIZE + c)*DATA_SIZE +: DATA_SIZE] =
                bank_mem[rd_ptr][AW'(r)][c*DATA_SIZE +: DATA_SIZE];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_row_buff_pingpong.sv
// tb/tb_row_buff_pingpong.sv - directed self-checking bench for row_buff_pingpong
module tb_row_buff_pingpong;

  localparam int DS = 8;
  localparam int RS = 2;
  localparam int CS = 3;

  logic                  clock;
  logic                  reset;
  logic                  enable;
  logic                  din_valid;
  logic                  din_ready;
  logic [DS*RS-1:0]      dats;
  logic                  dendFlag;
  logic                  transpose;
  logic                  dsetFlag;
  logic                  dout_ready;
  logic [DS*CS*RS-1:0]   datsOut;
  logic [1:0]            rowCount;

  int checks;
  int failures;

  row_buff_pingpong #(
    .DATA_SIZE  (DS),
    .ROW_SIZE   (RS),
    .COLUMN_SIZE(CS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dats      (dats),
    .dendFlag  (dendFlag),
    .transpose (transpose),
    .dsetFlag  (dsetFlag),
    .dout_ready(dout_ready),
    .datsOut   (datsOut),
    .rowCount  (rowCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; din_valid = 1'b0; dats = '0;
    dendFlag = 1'b0; transpose = 1'b0; dout_ready = 1'b0;
    step(); step();
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL reset_dset got=%b exp=0", dsetFlag); end
    checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
    checks++; if (rowCount !== 2'd0) begin failures++; $display("FAIL reset_rowcount got=%0d exp=0", rowCount); end
    checks++; if (datsOut !== 48'h0) begin failures++; $display("FAIL reset_datsout got=%h exp=0", datsOut); end
    reset = 1'b1;
    #1;
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", din_ready); end
  endtask

  task automatic test_basic();
    dout_ready = 1'b1; transpose = 1'b0; din_valid = 1'b1;
    dats = 16'h0201; step();
    dats = 16'h0403; step();
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL basic_early_dset got=%b exp=0", dsetFlag); end
    dats = 16'h0605; step();
    din_valid = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL basic_dset got=%b exp=1", dsetFlag); end
    checks++; if (datsOut !== 48'h060504030201) begin failures++; $display("FAIL basic_datsout got=%h exp=060504030201", datsOut); end
    checks++; if (rowCount !== 2'd3) begin failures++; $display("FAIL basic_rowcount got=%0d exp=3", rowCount); end
    step();
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL basic_pop_dset got=%b exp=0", dsetFlag); end
    checks++; if (datsOut !== 48'h0) begin failures++; $display("FAIL basic_pop_datsout got=%h exp=0", datsOut); end
  endtask

  task automatic test_transpose();
    dout_ready = 1'b1; din_valid = 1'b1;
    transpose = 1'b1; dats = 16'h0201; step();
    transpose = 1'b0; dats = 16'h0403; step();
    dats = 16'h0605; step();
    din_valid = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL tr_dset got=%b exp=1", dsetFlag); end
    checks++; if (datsOut !== 48'h060402050301) begin failures++; $display("FAIL tr_datsout got=%h exp=060402050301", datsOut); end
    checks++; if (rowCount !== 2'd3) begin failures++; $display("FAIL tr_rowcount got=%0d exp=3", rowCount); end
    step();
  endtask

  task automatic test_early_end();
    dout_ready = 1'b1; transpose = 1'b0;
    din_valid = 1'b1; dendFlag = 1'b1; dats = 16'h0B0A; step();
    din_valid = 1'b0; dendFlag = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL early_dset got=%b exp=1", dsetFlag); end
    checks++; if (rowCount !== 2'd1) begin failures++; $display("FAIL early_rowcount got=%0d exp=1", rowCount); end
    checks++; if (datsOut !== 48'h000000000B0A) begin failures++; $display("FAIL early_datsout got=%h exp=000000000b0a", datsOut); end
    step();
    dendFlag = 1'b1; step();
    dendFlag = 1'b0;
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL lone_end_dset got=%b exp=0", dsetFlag); end
    step();
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL lone_end_dset2 got=%b exp=0", dsetFlag); end
    din_valid = 1'b1; dats = 16'h0D0C; step();
    din_valid = 1'b0; dendFlag = 1'b1; step();
    dendFlag = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL idle_end_dset got=%b exp=1", dsetFlag); end
    checks++; if (rowCount !== 2'd1) begin failures++; $display("FAIL idle_end_rowcount got=%0d exp=1", rowCount); end
    checks++; if (datsOut !== 48'h000000000D0C) begin failures++; $display("FAIL idle_end_datsout got=%h exp=000000000d0c", datsOut); end
    step();
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0; transpose = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dats = {8'(2*i + 2), 8'(2*i + 1)};
      din_valid = 1'b1;
      #1;
      checks++;
      if (din_ready !== (i < 6)) begin
        failures++; $display("FAIL bp_ready_row%0d got=%b exp=%b", i, din_ready, (i < 6));
      end
      step();
    end
    step();
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL bp_hold_dset got=%b exp=1", dsetFlag); end
    checks++; if (datsOut !== 48'h060504030201) begin failures++; $display("FAIL bp_first_datsout got=%h exp=060504030201", datsOut); end
    dout_ready = 1'b1;
    #1;
    checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", din_ready); end
    step();
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL bp_freed_ready got=%b exp=1", din_ready); end
    checks++; if (datsOut !== 48'h0C0B0A090807) begin failures++; $display("FAIL bp_second_datsout got=%h exp=0c0b0a090807", datsOut); end
    step();
    checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL bp_drained_dset got=%b exp=0", dsetFlag); end
    dats = 16'h100F; step();
    dats = 16'h1211; step();
    din_valid = 1'b0;
    checks++; if (datsOut !== 48'h1211100F0E0D) begin failures++; $display("FAIL bp_third_datsout got=%h exp=1211100f0e0d", datsOut); end
    step();
  endtask

  task automatic test_enable();
    dout_ready = 1'b0; transpose = 1'b0; din_valid = 1'b1;
    dats = 16'h2221; step();
    dats = 16'h2423; step();
    dats = 16'h2625; step();
    dats = 16'h0201; step();
    dout_ready = 1'b1; enable = 1'b0; dats = 16'h0403;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL en_ready_c%0d got=%b exp=0", k, din_ready); end
      step();
      checks++; if (datsOut !== 48'h262524232221 || dsetFlag !== 1'b1) begin
        failures++; $display("FAIL en_hold_c%0d got=%h/%b exp=262524232221/1", k, datsOut, dsetFlag);
      end
    end
    enable = 1'b1; step();
    dats = 16'h0605; step();
    din_valid = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL en_resume_dset got=%b exp=1", dsetFlag); end
    checks++; if (datsOut !== 48'h060504030201) begin failures++; $display("FAIL en_resume_datsout got=%h exp=060504030201", datsOut); end
    step();
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b1; transpose = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dats = {8'(8'h42 + 2*i), 8'(8'h41 + 2*i)};
      din_valid = 1'b1;
      #1;
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_row%0d got=%b exp=1", i, din_ready); end
      step();
      if (i == 2) begin
        checks++; if (datsOut !== 48'h464544434241) begin failures++; $display("FAIL b2b_m1 got=%h exp=464544434241", datsOut); end
      end
      if (i == 3) begin
        checks++; if (dsetFlag !== 1'b0) begin failures++; $display("FAIL b2b_gap_dset got=%b exp=0", dsetFlag); end
      end
    end
    din_valid = 1'b0;
    checks++; if (datsOut !== 48'h4C4B4A494847) begin failures++; $display("FAIL b2b_m2 got=%h exp=4c4b4a494847", datsOut); end
    step();
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0; transpose = 1'b0; din_valid = 1'b1;
    dats = 16'h0201; step();
    reset = 1'b0; step();
    checks++; if (dsetFlag !== 1'b0 || datsOut !== 48'h0 || din_ready !== 1'b0) begin
      failures++; $display("FAIL rst_filling got=%b/%h/%b exp=0/0/0", dsetFlag, datsOut, din_ready);
    end
    reset = 1'b1;
    dats = 16'h0201; step();
    dats = 16'h0403; step();
    dats = 16'h0605; step();
    din_valid = 1'b0;
    checks++; if (dsetFlag !== 1'b1) begin failures++; $display("FAIL rst_prefull_dset got=%b exp=1", dsetFlag); end
    reset = 1'b0; step();
    checks++; if (dsetFlag !== 1'b0 || datsOut !== 48'h0 || din_ready !== 1'b0) begin
      failures++; $display("FAIL rst_full got=%b/%h/%b exp=0/0/0", dsetFlag, datsOut, din_ready);
    end
    reset = 1'b1; dout_ready = 1'b1; din_valid = 1'b1;
    transpose = 1'b1; dats = 16'h3231; step();
    transpose = 1'b0; dats = 16'h3433; step();
    dats = 16'h3635; step();
    din_valid = 1'b0;
    checks++; if (datsOut !== 48'h363432353331) begin failures++; $display("FAIL rst_after_datsout got=%h exp=363432353331", datsOut); end
    checks++; if (rowCount !== 2'd3) begin failures++; $display("FAIL rst_after_rowcount got=%0d exp=3", rowCount); end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_transpose();
    test_early_end();
    test_backpressure();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_buff_pingpong.md
Name: row_buff_pingpong

Overview:
- Parametrised successor to the matrix_mdl row buffer.
- Collects a matrix one row per beat, with valid/ready input handshake, into two ping-pong banks, so the next matrix fills while the previous one is presented.
- Supports early termination with zero-fill and an optional per-matrix transposed output layout.
- Sits between the row-stream producer and matrix_mdl.

Parameters:
- DATA_SIZE, 16, bits per element.
- ROW_SIZE, 16, elements per input row (one beat).
- COLUMN_SIZE, 16, rows per full matrix (beats per matrix).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global advance; low freezes all state.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid && din_ready.
- dats  in  DATA_SIZE*ROW_SIZE  one row; element c at bits [c*DATA_SIZE +: DATA_SIZE].
- dendFlag  in  1  early end of matrix.
- transpose  in  1  layout select, latched on the first beat of each matrix.
- dsetFlag  out  1  output matrix valid.
- dout_ready  in  1  consumer accepts when dsetFlag && dout_ready && enable.
- datsOut  out  DATA_SIZE*COLUMN_SIZE*ROW_SIZE  presented matrix.
- rowCount  out  clog2(COLUMN_SIZE+1)  number of real rows in the presented matrix.

Behaviour:
- Reset, synchronous on clock edge with reset==0:
  - both banks EMPTY, write row counter = 0, fill pointer = bank 0, read pointer = bank 0.
  - dsetFlag = 0, din_ready = 0, rowCount = 0, datsOut = 0.
  - Bank storage need not be cleared.
  - Reset mid-fill or mid-presentation discards everything.
- Per-bank state: EMPTY -> FILLING (first beat accepted) -> FULL (closed) -> EMPTY (output handshake).
- din_ready = enable && reset && fill bank is EMPTY or FILLING.
- Accepted beat:
  - writes dats into row[count] of the fill bank; count += 1.
  - If that beat has dendFlag=1, or the new count == COLUMN_SIZE, the bank goes FULL with rows = new count.
  - Then count = 0 and the fill pointer toggles.
- dendFlag with no accepted beat:
  - If count > 0, close the bank with rows = count.
  - If count == 0, ignore it; empty matrices are never produced.
- Output side:
  - dsetFlag = 1 iff the read-pointer bank is FULL.
  - Banks are presented strictly in fill order.
  - On handshake the bank goes EMPTY and the read pointer toggles next edge.
- Latency: last row accepted at edge N -> dsetFlag=1 after edge N, provided the read bank was otherwise EMPTY.
- Throughput: one row per cycle sustained if the consumer takes each matrix within COLUMN_SIZE cycles.
- Simultaneous events:
  - The output handshake on bank A and the closing of bank B on the same edge are both honoured.
  - A bank freed on edge N is writable from edge N+1; din_ready rises after edge N.
- Both banks FULL: din_ready=0, no data lost.
- enable=0: no accepts, no handshakes, no state change; outputs hold.
- datsOut layout, row r < rowCount, element c:
  - transpose=0: element at index r*ROW_SIZE + c.
  - transpose=1: element at index c*COLUMN_SIZE + r.
  - Each index selects the field [idx*DATA_SIZE +: DATA_SIZE].
- Zero-fill: rows r >= rowCount read as 0 in either layout.
- When dsetFlag=0, datsOut=0 and rowCount=0.
- dats is don't-care when din_valid=0.

Test Plan:
- Params DATA_SIZE=8, ROW_SIZE=2, COLUMN_SIZE=3.
  - Stimulus: reset low 2 cycles, then feed rows {0x02,0x01},{0x04,0x03},{0x06,0x05}, transpose=0, dout_ready=1.
  - Response: dsetFlag=1 one cycle after the third accept, datsOut=0x060504030201, rowCount=3.
- Same rows with transpose=1 on the first beat -> datsOut=0x060402050301, rowCount=3.
- Early end:
  - Stimulus: feed {0x0B,0x0A} with dendFlag=1.
  - Response: rowCount=1, datsOut=0x000000000B0A.
  - A subsequent lone dendFlag with count=0 produces no dsetFlag.
- Backpressure:
  - Stimulus: hold dout_ready=0 and stream 9 rows.
  - Response: two matrices captured, din_ready=0 from the 7th row onward.
  - Then release dout_ready: matrices emerge in order, and din_ready rises the cycle after the first handshake.
- enable=0 for 5 cycles mid-fill with din_valid=1 -> count unchanged, no accepts, dsetFlag/datsOut held; fill resumes correctly.
- Assert reset during FILLING and while FULL -> next cycle dsetFlag=0, datsOut=0, din_ready=0; first matrix after reset is correct.
